// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size codes, FSM states and byte-count helper for lsu_bus_port
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT1 = 3'd1,
    GAP   = 3'd2,
    BEAT2 = 3'd3,
    RESP  = 3'd4
  } state_t;

  function automatic logic [3:0] bytes_of(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane shift/strobes and load merge/extend
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]   off,
  input  logic [1:0]      sz,
  input  logic            sgn,
  input  logic            hi,
  input  logic            split,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] hold_data,
  input  logic [XLEN-1:0] bus_data,
  output logic [NB-1:0]   lane_strb,
  output logic [XLEN-1:0] lane_data,
  output logic [XLEN-1:0] ld_data
);

  logic [3:0]        nbytes;
  logic [2*NB-1:0]   strb_w;
  logic [2*XLEN-1:0] data_w;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   keep;
  logic              sbit;

  // Both beats are viewed as one double-width window; beat 2 is its upper half.
  always_comb begin
    nbytes    = bytes_of(sz);
    strb_w    = ((2*NB)'(1) << nbytes) - (2*NB)'(1);
    strb_w    = strb_w << off;
    data_w    = {{XLEN{1'b0}}, st_data} << (8 * off);
    lane_strb = hi ? strb_w[2*NB-1:NB] : strb_w[NB-1:0];
    lane_data = hi ? data_w[2*XLEN-1:XLEN] : data_w[XLEN-1:0];

    merged = split ? {bus_data, hold_data} : {{XLEN{1'b0}}, bus_data};
    merged = merged >> (8 * off);
    raw    = merged[XLEN-1:0];
    keep   = '0;
    sbit   = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      keep[i] = (i < 8 * int'(nbytes));
      if (i == 8 * int'(nbytes) - 1) sbit = sgn & raw[i];
    end
    ld_data = (raw & keep) | ({XLEN{sbit}} & ~keep);
  end

endmodule

// File: rtl/lsu_bus_port.sv
// rtl/lsu_bus_port.sv - load/store bus port with split beats; LSU_TIMEOUT_EN adds a ready watchdog
module lsu_bus_port
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [AW-1:0]     addr,
  output logic [2:0]        size,
  output logic              valid,
  output logic              write,
  output logic [XLEN/8-1:0] wstrb,
  output logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  input  logic              ready
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  state_t          state, state_nx;
  logic            r_write, r_signed, r_split, r_err;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata, r_hold, r_rdata;
  logic [AW-1:0]   base;
  logic            in_beat, to_hit, illegal, split_req;
  logic [NB-1:0]   la_strb;
  logic [XLEN-1:0] la_data, la_ld;

  assign in_beat   = (state == BEAT1) || (state == BEAT2);
  assign base      = {r_addr[AW-1:OW], {OW{1'b0}}};
  assign illegal   = (XLEN == 32) && (req_size == SZ_D);
  assign split_req = (int'(req_addr[OW-1:0]) + int'(bytes_of(req_size))) > NB;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || !in_beat || ready) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + 1'b1;
  end

  assign to_hit = in_beat && !ready && (wd_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = illegal ? RESP : BEAT1;
      BEAT1:   if (ready) state_nx = r_split ? GAP : RESP;
               else if (to_hit) state_nx = RESP;
      GAP:     state_nx = BEAT2;
      BEAT2:   if (ready || to_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, beat-1 read data hold and final response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_split  <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_hold   <= '0;
      r_rdata  <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        r_write  <= req_write;
        r_signed <= req_signed;
        r_split  <= split_req;
        r_size   <= req_size;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= illegal;
        r_rdata  <= '0;
      end
      if (state == BEAT1 && ready) begin
        r_hold <= rdata;
        if (!r_split) r_rdata <= r_write ? '0 : la_ld;
      end
      if (state == BEAT2 && ready) r_rdata <= r_write ? '0 : la_ld;
      if (to_hit) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .off       (r_addr[OW-1:0]),
    .sz        (r_size),
    .sgn       (r_signed),
    .hi        (state == BEAT2),
    .split     (r_split),
    .st_data   (r_wdata),
    .hold_data (r_hold),
    .bus_data  (rdata),
    .lane_strb (la_strb),
    .lane_data (la_data),
    .ld_data   (la_ld)
  );

  always_comb begin
    valid     = in_beat;
    write     = 1'b0;
    size      = '0;
    addr      = '0;
    wstrb     = '0;
    wdata     = '0;
    if (in_beat) begin
      write = r_write;
      size  = 3'(OW);
      addr  = (state == BEAT2) ? base + AW'(NB) : base;
      wstrb = la_strb;
      wdata = r_write ? la_data : '0;
    end
    rsp_valid = (state == RESP);
    rsp_err   = rsp_valid && r_err;
    rsp_rdata = rsp_valid ? r_rdata : '0;
    busy      = (state != IDLE);
    req_ready = (state == IDLE) && !rst;
  end

endmodule

// File: tb/tb_lsu_bus_port.sv
// tb/tb_lsu_bus_port.sv - directed table plus randomized accesses against a byte-memory model
`timescale 1ns/1ps
module tb_lsu_bus_port;

  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy, valid, write;
  logic [31:0] rsp_rdata, addr, wdata;
  logic [2:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_bus_port #(.XLEN(XLEN), .AW(AW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .addr(addr),
    .size(size), .valid(valid), .write(write), .wstrb(wstrb), .wdata(wdata),
    .rdata(rdata), .ready(ready)
  );

  bit [7:0] bus_mem [int unsigned];
  bit [7:0] ref_mem [int unsigned];
  logic [31:0] beat_addr [$];
  logic [3:0]  beat_strb [$];
  int max_wait = 0;
  bit hold_ready = 0;

  function automatic bit [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic bit [7:0] rd_bus(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction
  function automatic bit [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      bus_mem[a + k] = w[8*k +: 8];
      ref_mem[a + k] = w[8*k +: 8];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory-side responder: random wait per beat, random ready noise while valid is low.
  initial begin : responder
    bit in_b;
    int wl;
    logic [31:0] w;
    in_b = 0;
    wl = 0;
    forever begin
      @(negedge clk);
      if (hold_ready) begin
        in_b = 0;
        ready = 1'b0;
      end else if (valid) begin
        if (!in_b) begin
          in_b = 1;
          wl = $urandom_range(0, max_wait);
        end
        if (wl == 0) begin
          for (int k = 0; k < 4; k++) w[8*k +: 8] = rd_bus(addr + k);
          if (write)
            for (int k = 0; k < 4; k++) if (wstrb[k]) bus_mem[addr + k] = wdata[8*k +: 8];
          beat_addr.push_back(addr);
          beat_strb.push_back(wstrb);
          rdata = write ? $urandom : w;
          ready = 1'b1;
          in_b = 0;
        end else begin
          ready = 1'b0;
          rdata = $urandom;
          wl--;
        end
      end else begin
        in_b = 0;
        ready = 1'($urandom_range(0, 1));
        rdata = $urandom;
      end
    end
  end

  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int cyc);
    beat_addr.delete();
    beat_strb.delete();
    issue(wr, sz, sg, a, wd);
    cyc = 1;
    while (!rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 1'b0);
  endtask

  // Expected values come from byte-level rules: each accessed byte lands in the word containing it.
  task automatic txn(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit use_tbl, input logic [31:0] tbl_rd, input int exp_cyc);
    int nb, nbeats, cyc;
    bit ill, er;
    logic [31:0] exp_rd, rd;
    logic [31:0] ea [2];
    logic [3:0]  es [2];
    nb = 1 << sz;
    ill = (sz == 2'd3);
    ea[0] = a & ~32'h3;
    ea[1] = ea[0] + 32'd4;
    es[0] = '0;
    es[1] = '0;
    nbeats = 0;
    exp_rd = '0;
    if (!ill) begin
      for (int k = 0; k < nb; k++) begin
        logic [31:0] ba;
        int bi;
        ba = a + k;
        bi = ((ba & ~32'h3) == ea[0]) ? 0 : 1;
        es[bi][ba[1:0]] = 1'b1;
        if (wr) ref_mem[ba] = wd[8*k +: 8];
        else    exp_rd[8*k +: 8] = rd_ref(ba);
      end
      nbeats = (es[1] != 0) ? 2 : 1;
      if (!wr && sg && exp_rd[8*nb-1])
        for (int k = nb; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
    end
    access(wr, sz, sg, a, wd, rd, er, cyc);
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " err"}, er, ill);
    chk({tag, " beats"}, beat_addr.size(), nbeats);
    for (int i = 0; i < nbeats && i < beat_addr.size(); i++) begin
      chk({tag, " beat_addr"}, beat_addr[i], ea[i]);
      chk({tag, " beat_strb"}, beat_strb[i], es[i]);
    end
    if (use_tbl) chk({tag, " table_rdata"}, rd, tbl_rd);
    if (exp_cyc > 0) chk({tag, " latency"}, cyc, exp_cyc);
  endtask

  typedef struct {
    string       name;
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt [10];
    int vcnt, cyc, mism;
    logic [31:0] rd;
    bit er;

    vt[0] = '{"lw_aligned",  1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2};
    vt[1] = '{"lb_signed",   1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0,         32'hFFFF_FF80, 2};
    vt[2] = '{"lb_unsigned", 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0,         32'h0000_0080, 2};
    vt[3] = '{"sh_split",    1'b1, 2'd1, 1'b0, 32'h0000_0303, 32'h0000_1234, 32'h0,         4};
    vt[4] = '{"lh_split",    1'b0, 2'd1, 1'b0, 32'h0000_0303, 32'h0,         32'h0000_1234, 4};
    vt[5] = '{"lw_split",    1'b0, 2'd2, 1'b0, 32'h0000_0402, 32'h0,         32'hCCDD_AABB, 4};
    vt[6] = '{"illegal_sz",  1'b0, 2'd3, 1'b0, 32'h0000_0500, 32'h0,         32'h0,         1};
    vt[7] = '{"lw_wrap",     1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h3344_5566, 4};
    vt[8] = '{"sw_aligned",  1'b1, 2'd2, 1'b0, 32'h0000_0600, 32'hCAFE_F00D, 32'h0,         2};
    vt[9] = '{"lh_signed",   1'b0, 2'd1, 1'b1, 32'h0000_0601, 32'h0,         32'hFFFF_FEF0, 2};

    poke(32'h0000_0100, 32'hDEAD_BEEF);
    poke(32'h0000_0200, 32'h80FF_FFFF);
    poke(32'h0000_0400, 32'hAABB_1122);
    poke(32'h0000_0404, 32'h3344_CCDD);
    poke(32'hFFFF_FFFC, 32'h5566_7788);
    poke(32'h0000_0000, 32'h1122_3344);

    repeat (3) @(negedge clk);
    chk("rst req_ready", req_ready, 1'b0);
    chk("rst outputs", {valid, write, size, addr, wstrb, busy, rsp_valid, rsp_err},
        {1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0});
    chk("rst wdata_rdata", {wdata, rsp_rdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst req_ready", req_ready, 1'b1);

    max_wait = 0;
    for (int i = 0; i < 10; i++)
      txn(vt[i].name, vt[i].wr, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, 1'b1, vt[i].exp_rd, vt[i].exp_cyc);

    // Reset while a beat is waiting on ready.
    hold_ready = 1;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    repeat (2) @(negedge clk);
    chk("mid_rst valid_before", valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst valid_after", valid, 1'b0);
    chk("mid_rst busy", busy, 1'b0);
    rst = 1'b0;
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    chk("mid_rst no_rsp", vcnt, 0);
    chk("mid_rst req_ready", req_ready, 1'b1);

`ifdef LSU_TIMEOUT_EN
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    vcnt = 0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      if (valid) vcnt++;
      @(negedge clk);
      cyc++;
    end
    chk("timeout valid_cycles", vcnt, 4);
    chk("timeout latency", cyc, 5);
    chk("timeout rsp", {rsp_valid, rsp_err}, 2'b11);
    chk("timeout rdata", rsp_rdata, 32'h0);
    hold_ready = 0;
    @(negedge clk);
`else
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0);
    vcnt = 0;
    repeat (20) begin
      if (rsp_valid) vcnt++;
      @(negedge clk);
    end
    chk("no_timeout still_valid", valid, 1'b1);
    chk("no_timeout no_rsp", vcnt, 0);
    hold_ready = 0;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("no_timeout rsp", {rsp_valid, rsp_err}, 2'b10);
    chk("no_timeout rdata", rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
`endif

    max_wait = 3;
    for (int i = 0; i < 200; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      txn("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          32'h0000_0800 + $urandom_range(0, 31), $urandom, 1'b0, 32'h0, 0);
    end

    mism = 0;
    for (int a = 32'h7F0; a < 32'h830; a++) if (rd_bus(a) != rd_ref(a)) mism++;
    chk("mem_image", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
